// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
// evaluated CHUNK bits per clock, least-significant chunk first, with the
// inter-chunk carry held in a register. N = WIDTH/CHUNK cycles per result.
//
// Parameters:
//   WIDTH      operand/result width (>= 2)
//   CHUNK      bits per cycle (>= 1, divides WIDTH)
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   start_i     request a new operation (accepted in IDLE or DONE)
//   a_i, b_i    operands, captured on the accepting edge
//   cin_i       carry-in (add) / borrow-in (subtract)
//   sub_i       0: a+b+cin, 1: a-b-cin
//   busy_o      operation in progress
//   done_o      one-cycle pulse, result valid
//   sum_o       result (partially updated while busy)
//   carry_o     raw carry-out of the MSB (subtract: 1 = no borrow)
//   overflow_o  signed overflow (carry into MSB xor carry out of MSB)
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCarry;
  logic             msbCarryIn;
  logic             accept;
  logic             lastChunk;

  // Chunk adder: a CHUNK-bit full-adder chain fed by the carry register.
  // The carry into the chunk's top bit is recovered from that bit's sum
  // (s = a ^ b ^ cin), which is all the overflow detector needs.
  always_comb begin
    chunkA   = opA_q[k_q*CHUNK +: CHUNK];
    chunkB   = opB_q[k_q*CHUNK +: CHUNK];
    {chunkCarry, chunkSum} = {1'b0, chunkA} + {1'b0, chunkB}
                           + {{CHUNK{1'b0}}, cy_q};
    msbCarryIn = chunkSum[CHUNK-1] ^ chunkA[CHUNK-1] ^ chunkB[CHUNK-1];
  end

  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start_i;
  assign lastChunk = (k_q == KW'(N - 1));

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic. Subtraction is A + ~B + ~borrow, so B is inverted and
  // the carry register seeded with cin ^ sub when the operation is accepted.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: state_d = IDLE;
      RUN: begin
        sum_d[k_q*CHUNK +: CHUNK] = chunkSum;
        cy_d = chunkCarry;
        if (lastChunk) begin
          // k is cleared explicitly because N need not be a power of two.
          k_d     = '0;
          carry_d = chunkCarry;
          ovf_d   = msbCarryIn ^ chunkCarry;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      opA_d   = a_i;
      opB_d   = b_i ^ {WIDTH{sub_i}};
      cy_d    = cin_i ^ sub_i;
      k_d     = '0;
      state_d = RUN;
    end
  end

  // Outputs.
  always_comb begin
    busy_o     = (state_q == RUN);
    done_o     = (state_q == DONE);
    sum_o      = sum_q;
    carry_o    = carry_q;
    overflow_o = ovf_q;
  end

endmodule
